int_sequencer: RTL

//  Sequences exception entry/exit for the core. Synchronises the NIRQ active-low external

---
 rtl/int_sequencer_pkg.sv | 31 +++
 rtl/int_sequencer_if.sv | 11 +
 rtl/int_sync.sv | 35 +++
 rtl/int_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/int_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: FSM states, source tags,
// reserved vector values and the pending-line priority helper.
package int_sequencer_pkg;

    localparam int NIRQ_MAX  = 4;
    localparam int TRAP_MIN  = 4;
    localparam int VEC_RESET = 31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_ACK     = 2'd2,
        ST_SERVICE = 2'd3
    } state_t;

    typedef enum logic {
        SRC_IRQ  = 1'b0,
        SRC_TRAP = 1'b1
    } src_t;

    // Highest-index set bit wins; returns 0 when nothing is pending.
    function automatic logic [1:0] top_index(input logic [NIRQ_MAX-1:0] p);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 0; k < NIRQ_MAX; k++) begin
            if (p[k]) idx = 2'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_sequencer_if.sv
// Exception handshake between the sequencer (master) and the core fetch stage (slave).
interface int_sequencer_if #(parameter int VEC_W = 5);

    logic             exception;
    logic [VEC_W-1:0] vector;
    logic             core_ack;

    modport master (output exception, output vector, input core_ack);
    modport slave  (input exception, input vector, output core_ack);

endinterface

// File: rtl/int_sync.sv
// One interrupt line: SYNC_STAGES-deep synchroniser, active-high level out.
// With INT_EDGE_EN defined, also a one-cycle pulse on each synchronised assertion.
module int_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line_n,
`ifdef INT_EDGE_EN
    output logic fall,
`endif
    output logic level
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], line_n};
    end

    assign level = ~sync_q[SYNC_STAGES-1];

`ifdef INT_EDGE_EN
    logic level_q;

    always_ff @(posedge clk) begin
        if (rst) level_q <= 1'b0;
        else     level_q <= level;
    end

    assign fall = level & ~level_q;
`endif

endmodule

// File: rtl/int_sequencer.sv
// Exception entry/exit sequencer: IRQ pending/priority, trap arbitration, IE ownership.
// Build option INT_EDGE_EN selects edge-latched pending lines instead of level mode.
module int_sequencer
    import int_sequencer_pkg::*;
#(
    parameter int NIRQ        = 3,
    parameter int VEC_W       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NIRQ-1:0]      oint_n,
    input  logic [VEC_W-1:0]     trap_vec,
    input  logic                 ie_set,
    input  logic                 ie_clr,
    input  logic                 reti,
    int_sequencer_if.master      core,
    output logic                 iack_n,
    output logic                 ie,
    output logic [NIRQ-1:0]      in_service,
    output logic                 double_fault
);

    state_t            state_q, state_d;
    src_t              src_q;
    logic [1:0]        line_q;
    logic [VEC_W-1:0]  vector_q;
    logic              ie_q, ie_saved_q, ie_saved_nxt;
    logic [NIRQ-1:0]   in_service_q;
    logic              double_fault_q;
    logic [NIRQ-1:0]   pending_q;
    logic [NIRQ-1:0]   level_w;
    logic [NIRQ_MAX-1:0] pend_ext;
    logic [NIRQ-1:0]   line_onehot;
    logic              trap_req, irq_req;
    logic              take_trap, take_irq;

`ifdef INT_EDGE_EN
    logic [NIRQ-1:0]   fall_w;
    logic [NIRQ-1:0]   clr_mask;
`endif

    for (genvar g = 0; g < NIRQ; g++) begin : g_sync
        int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .rst    (rst),
            .line_n (oint_n[g]),
`ifdef INT_EDGE_EN
            .fall   (fall_w[g]),
`endif
            .level  (level_w[g])
        );
    end

    // The reset vector is never a legal trap target.
    assign trap_req = (trap_vec >= VEC_W'(TRAP_MIN)) && (trap_vec != VEC_W'(VEC_RESET));
    assign irq_req  = ie_q && (pending_q != '0);
    assign line_onehot = NIRQ'(1) << line_q;

    always_comb begin
        pend_ext = '0;
        pend_ext[NIRQ-1:0] = pending_q;
    end

    always_comb begin
        state_d   = state_q;
        take_trap = 1'b0;
        take_irq  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trap_req) begin
                    take_trap = 1'b1;
                    state_d   = ST_REQ;
                end else if (irq_req) begin
                    take_irq = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (core.core_ack)                      state_d = ST_ACK;
                else if ((src_q == SRC_IRQ) && ie_clr)  state_d = ST_IDLE;
            end
            ST_ACK:     state_d = ST_SERVICE;
            ST_SERVICE: if (reti) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    assign ie_saved_nxt = ie_clr ? 1'b0 : (ie_set ? 1'b1 : ie_saved_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q          <= SRC_IRQ;
            line_q         <= 2'd0;
            vector_q       <= '0;
            ie_q           <= 1'b0;
            ie_saved_q     <= 1'b0;
            in_service_q   <= '0;
            double_fault_q <= 1'b0;
        end else begin
            if (take_trap) begin
                src_q    <= SRC_TRAP;
                vector_q <= trap_vec;
            end else if (take_irq) begin
                src_q    <= SRC_IRQ;
                line_q   <= top_index(pend_ext);
                vector_q <= VEC_W'(top_index(pend_ext)) + VEC_W'(1);
            end

            // While servicing, EI/DI edit the value that RETI will restore.
            case (state_q)
                ST_ACK: begin
                    ie_saved_q   <= ie_q;
                    ie_q         <= 1'b0;
                    in_service_q <= (src_q == SRC_IRQ) ? line_onehot : '0;
                end
                ST_SERVICE: begin
                    ie_saved_q <= ie_saved_nxt;
                    if (reti) begin
                        ie_q         <= ie_saved_nxt;
                        in_service_q <= '0;
                    end
                    if (trap_req) double_fault_q <= 1'b1;
                end
                default: begin
                    if (ie_clr)      ie_q <= 1'b0;
                    else if (ie_set) ie_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef INT_EDGE_EN
    assign clr_mask = ((state_q == ST_ACK) && (src_q == SRC_IRQ)) ? line_onehot : '0;

    // A fresh edge on the line being acknowledged must survive the clear.
    always_ff @(posedge clk) begin
        if (rst) pending_q <= '0;
        else     pending_q <= (pending_q & ~clr_mask) | fall_w;
    end
`else
    always_ff @(posedge clk) begin
        if (rst) pending_q <= '0;
        else     pending_q <= level_w;
    end
`endif

    assign core.exception = (state_q == ST_REQ);
    assign core.vector    = vector_q;
    assign iack_n         = !((state_q == ST_ACK) && (src_q == SRC_IRQ));
    assign ie             = ie_q;
    assign in_service     = in_service_q;
    assign double_fault   = double_fault_q;

endmodule
